// File: rtl/clock_display_serializer_if.sv
// Bus between the time source / sequencer and the display serializer:
// captured time, request strobes, and the serial display-driver lines.
interface clock_display_serializer_if;
    logic [4:0] i_hours;
    logic [5:0] i_minutes;
    logic [5:0] i_seconds;
    logic       i_start_stb;
    logic       i_serial_stb;
    logic       o_busy;
    logic       o_done_stb;
    logic       o_sclk;
    logic       o_sdata;
    logic       o_latch;

    modport master (
        output i_hours, i_minutes, i_seconds, i_start_stb, i_serial_stb,
        input  o_busy, o_done_stb, o_sclk, o_sdata, o_latch
    );

    modport slave (
        input  i_hours, i_minutes, i_seconds, i_start_stb, i_serial_stb,
        output o_busy, o_done_stb, o_sclk, o_sdata, o_latch
    );
endinterface

// File: rtl/clock_display_serializer.sv
// Captures hh:mm:ss, converts each field to BCD by repeated subtraction and
// shifts the 24-bit digit frame MSB first to a latching display driver.
module clock_display_serializer #(
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    clock_display_serializer_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, CONVERT, SHIFT_LOW, SHIFT_HIGH, LATCH} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [4:0]  r_hRem;
    logic [5:0]  r_mRem;
    logic [5:0]  r_sRem;
    logic [3:0]  r_hTens;
    logic [3:0]  r_mTens;
    logic [3:0]  r_sTens;
    logic [23:0] r_frame;
    logic [23:0] w_frameNext;
    logic [23:0] w_frameLoad;
    logic [4:0]  r_bitCnt;
    logic        r_busy, r_done, r_sclk, r_sdata, r_latch;
    logic        w_busy, w_done, w_sclk, w_sdata, w_latch;
    logic        w_allBelowTen;
    logic [3:0]  w_hTensDigit;

    assign w_allBelowTen = (r_hRem < 5'd10) && (r_mRem < 6'd10) && (r_sRem < 6'd10);
    assign w_hTensDigit  = (BLANK_LEADING_ZERO && (r_hTens == 4'd0)) ? 4'hF : r_hTens;
    assign w_frameLoad   = {w_hTensDigit, r_hRem[3:0], r_mTens, r_mRem[3:0],
                            r_sTens, r_sRem[3:0]};

    assign bus.o_busy     = r_busy;
    assign bus.o_done_stb = r_done;
    assign bus.o_sclk     = r_sclk;
    assign bus.o_sdata    = r_sdata;
    assign bus.o_latch    = r_latch;

    // State register; outputs are registered from the values the next state will present.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_sclk  <= w_sclk;
            r_sdata <= w_sdata;
            r_latch <= w_latch;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:       if (bus.i_start_stb)  w_nextState = CONVERT;
            CONVERT:    if (w_allBelowTen)    w_nextState = SHIFT_LOW;
            SHIFT_LOW:  if (bus.i_serial_stb) w_nextState = SHIFT_HIGH;
            SHIFT_HIGH: if (bus.i_serial_stb)
                            w_nextState = (r_bitCnt == 5'd23) ? LATCH : SHIFT_LOW;
            LATCH:      if (bus.i_serial_stb) w_nextState = IDLE;
            default:    w_nextState = IDLE;
        endcase
    end

    // The frame only shifts as o_sclk falls, so o_sdata holds through the high phase.
    always_comb begin
        w_frameNext = r_frame;
        if ((r_state == CONVERT) && w_allBelowTen)
            w_frameNext = w_frameLoad;
        else if ((r_state == SHIFT_HIGH) && bus.i_serial_stb)
            w_frameNext = {r_frame[22:0], 1'b0};
        w_busy  = (w_nextState != IDLE);
        w_done  = (r_state == LATCH) && bus.i_serial_stb;
        w_sclk  = (w_nextState == SHIFT_HIGH);
        w_latch = (w_nextState == LATCH);
        w_sdata = ((w_nextState == SHIFT_LOW) || (w_nextState == SHIFT_HIGH))
                  ? w_frameNext[23] : 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hRem   <= '0;
            r_mRem   <= '0;
            r_sRem   <= '0;
            r_hTens  <= '0;
            r_mTens  <= '0;
            r_sTens  <= '0;
            r_frame  <= '0;
            r_bitCnt <= '0;
        end else begin
            r_frame <= w_frameNext;
            case (r_state)
                IDLE: if (bus.i_start_stb) begin
                    r_hRem  <= bus.i_hours;
                    r_mRem  <= bus.i_minutes;
                    r_sRem  <= bus.i_seconds;
                    r_hTens <= '0;
                    r_mTens <= '0;
                    r_sTens <= '0;
                end
                CONVERT: begin
                    if (w_allBelowTen) begin
                        r_bitCnt <= '0;
                    end else begin
                        if (r_hRem >= 5'd10) begin
                            r_hRem  <= r_hRem - 5'd10;
                            r_hTens <= r_hTens + 4'd1;
                        end
                        if (r_mRem >= 6'd10) begin
                            r_mRem  <= r_mRem - 6'd10;
                            r_mTens <= r_mTens + 4'd1;
                        end
                        if (r_sRem >= 6'd10) begin
                            r_sRem  <= r_sRem - 6'd10;
                            r_sTens <= r_sTens + 4'd1;
                        end
                    end
                end
                SHIFT_HIGH: if (bus.i_serial_stb) r_bitCnt <= r_bitCnt + 5'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_display_serializer.sv
// Directed bench for clock_display_serializer: one instance with default
// leading-zero behaviour and one with blanking, fed the same stimulus.
module tb_clock_display_serializer;
    logic       clk = 1'b0;
    logic       resetN;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       startStb;
    logic       serialStb;

    always #5 clk = ~clk;

    clock_display_serializer_if bus0 ();
    clock_display_serializer_if bus1 ();

    assign bus0.i_hours = hours;     assign bus1.i_hours = hours;
    assign bus0.i_minutes = minutes; assign bus1.i_minutes = minutes;
    assign bus0.i_seconds = seconds; assign bus1.i_seconds = seconds;
    assign bus0.i_start_stb = startStb;   assign bus1.i_start_stb = startStb;
    assign bus0.i_serial_stb = serialStb; assign bus1.i_serial_stb = serialStb;

    clock_display_serializer #(.BLANK_LEADING_ZERO(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(resetN), .bus(bus0));
    clock_display_serializer #(.BLANK_LEADING_ZERO(1'b1)) dut1 (
        .i_clk(clk), .i_reset_n(resetN), .bus(bus1));

    // Output vector per instance: {busy, done, sclk, sdata, latch}
    logic [4:0] obsV [2];
    assign obsV[0] = {bus0.o_busy, bus0.o_done_stb, bus0.o_sclk, bus0.o_sdata, bus0.o_latch};
    assign obsV[1] = {bus1.o_busy, bus1.o_done_stb, bus1.o_sclk, bus1.o_sdata, bus1.o_latch};

    logic [4:0]  prevV [2];
    logic [23:0] bits [2];
    int sclkRises [2];
    int latchPulses [2];
    int donePulses [2];
    int busyErr [2];
    int sdataErr [2];
    int firstLat [2];
    int busyRiseCyc [2];
    int cyc, stbCnt, stbPeriod;
    int checks, failures;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMon();
        for (int i = 0; i < 2; i++) begin
            bits[i] = '0; sclkRises[i] = 0; latchPulses[i] = 0; donePulses[i] = 0;
            busyErr[i] = 0; sdataErr[i] = 0; firstLat[i] = -1; busyRiseCyc[i] = 0;
        end
    endtask

    task automatic monitor(input int i);
        logic [4:0] v;
        v = obsV[i];
        if (v[2] && !prevV[i][2]) begin
            sclkRises[i]++;
            bits[i] = {bits[i][22:0], v[1]};
            if (sclkRises[i] == 1) firstLat[i] = cyc - busyRiseCyc[i];
        end
        if (v[2] && prevV[i][2] && (v[1] !== prevV[i][1])) sdataErr[i]++;
        if (v[0] && !prevV[i][0]) latchPulses[i]++;
        if (v[3]) donePulses[i]++;
        if (v[4] && !prevV[i][4]) busyRiseCyc[i] = cyc;
        if (!v[4] && prevV[i][4] && !v[3]) busyErr[i]++;
        prevV[i] = v;
    endtask

    // One clock: sample #1 after the edge, then drive the next inputs.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        cyc++;
        startStb = 1'b0;
        for (int i = 0; i < 2; i++) monitor(i);
        stbCnt++;
        serialStb = ((stbCnt % stbPeriod) == 0);
    endtask

    task automatic setPeriod(input int p);
        stbPeriod = p;
        stbCnt = 0;
        serialStb = (p == 1);
    endtask

    task automatic startFrame(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        clearMon();
        hours = h; minutes = m; seconds = s;
        startStb = 1'b1;
        applyStimulus();
    endtask

    task automatic runUntilDone(input string tag, input int maxCycles);
        int n;
        n = 0;
        while ((donePulses[0] == 0) && (n < maxCycles)) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_finished"}, (donePulses[0] > 0) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) applyStimulus();
    endtask

    task automatic frameChecks(input string tag, input int i, input logic [23:0] expBits);
        checkOutput({tag, "_bits"}, {8'h0, bits[i]}, {8'h0, expBits});
        checkOutput({tag, "_sclk_rises"}, sclkRises[i], 24);
        checkOutput({tag, "_latch_pulses"}, latchPulses[i], 1);
        checkOutput({tag, "_done_pulses"}, donePulses[i], 1);
        checkOutput({tag, "_busy_gap"}, busyErr[i], 0);
        checkOutput({tag, "_sdata_stable"}, sdataErr[i], 0);
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0;
        hours = '0; minutes = '0; seconds = '0;
        startStb = 1'b0; serialStb = 1'b0; resetN = 1'b0;
        setPeriod(4);
        prevV[0] = '0; prevV[1] = '0;
        clearMon();

        repeat (3) applyStimulus();
        checkOutput("reset_outputs_dut0", obsV[0], 5'b0);
        checkOutput("reset_outputs_dut1", obsV[1], 5'b0);
        resetN = 1'b1;
        repeat (20) applyStimulus();
        checkOutput("idle_no_start_outputs", obsV[0], 5'b0);
        checkOutput("idle_no_start_sclk", sclkRises[0], 0);

        // 12:34:56 at one serial strobe every four clocks
        startFrame(5'd12, 6'd34, 6'd56);
        runUntilDone("f123456", 400);
        frameChecks("f123456", 0, 24'h123456);
        checkOutput("f123456_blank_bits", {8'h0, bits[1]}, 32'h123456);

        // Worst-case conversion, strobe every clock so latency exposes CONVERT length
        setPeriod(1);
        startFrame(5'd23, 6'd59, 6'd59);
        runUntilDone("f235959", 200);
        frameChecks("f235959", 0, 24'h235959);
        checkOutput("f235959_start_to_sclk", firstLat[0], 7);

        startFrame(5'd0, 6'd0, 6'd0);
        runUntilDone("f000000", 200);
        frameChecks("f000000", 0, 24'h000000);
        checkOutput("f000000_start_to_sclk", firstLat[0], 2);
        checkOutput("f000000_blank_bits", {8'h0, bits[1]}, 32'hF00000);

        startFrame(5'd9, 6'd5, 6'd0);
        runUntilDone("f090500", 200);
        frameChecks("f090500_blank", 1, 24'hF90500);
        checkOutput("f090500_plain_bits", {8'h0, bits[0]}, 32'h090500);

        startFrame(5'd10, 6'd0, 6'd0);
        runUntilDone("f100000", 200);
        checkOutput("f100000_blank_bits", {8'h0, bits[1]}, 32'h100000);

        startFrame(5'd31, 6'd63, 6'd0);
        runUntilDone("f316300", 200);
        checkOutput("f316300_bits", {8'h0, bits[0]}, 32'h316300);

        // Second start in the middle of shifting is ignored
        setPeriod(4);
        startFrame(5'd12, 6'd34, 6'd56);
        repeat (60) applyStimulus();
        hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
        startStb = 1'b1;
        applyStimulus();
        runUntilDone("midstart", 400);
        repeat (250) applyStimulus();
        frameChecks("midstart", 0, 24'h123456);
        checkOutput("midstart_idle_after", obsV[0][4], 1'b0);

        // Start coincident with the final latch strobe is ignored
        setPeriod(1);
        startFrame(5'd12, 6'd34, 6'd56);
        n = 0;
        while (!obsV[0][0] && (n < 200)) begin
            applyStimulus();
            n++;
        end
        checkOutput("latchstart_latch_seen", obsV[0][0], 1'b1);
        hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
        startStb = 1'b1;
        applyStimulus();
        checkOutput("latchstart_done_now", obsV[0][4:3], 2'b01);
        repeat (10) applyStimulus();
        checkOutput("latchstart_done_pulses", donePulses[0], 1);
        checkOutput("latchstart_stays_idle", obsV[0][4], 1'b0);
        checkOutput("latchstart_bits", {8'h0, bits[0]}, 32'h123456);

        // Asynchronous reset after the 10th sclk rise
        setPeriod(4);
        startFrame(5'd12, 6'd34, 6'd56);
        n = 0;
        while ((sclkRises[0] < 10) && (n < 300)) begin
            applyStimulus();
            n++;
        end
        checkOutput("midreset_tenth_edge", sclkRises[0], 10);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midreset_outputs_dut0", obsV[0], 5'b0);
        checkOutput("midreset_outputs_dut1", obsV[1], 5'b0);
        repeat (3) applyStimulus();
        resetN = 1'b1;
        clearMon();
        repeat (20) applyStimulus();
        checkOutput("postreset_no_frame", obsV[0], 5'b0);
        checkOutput("postreset_no_sclk", sclkRises[0], 0);
        startFrame(5'd12, 6'd34, 6'd56);
        runUntilDone("postreset", 400);
        frameChecks("postreset", 0, 24'h123456);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_display_serializer.md
CLOCK_DISPLAY_SERIALIZER -- requirements
Module: clock_display_serializer

Interface
REQ-001 Parameter: BLANK_LEADING_ZERO, default 0; when 1, an hours-tens digit of 0 SHALL be transmitted as 4'hF (blank code).
REQ-002 i_clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 i_hours  input  5  binary hours from the time register.
REQ-005 i_minutes  input  6  binary minutes.
REQ-006 i_seconds  input  6  binary seconds.
REQ-007 i_start_stb  input  1  one-cycle request to capture the time and transmit one frame.
REQ-008 i_serial_stb  input  1  one-cycle bit-rate enable; sets the serial half-period.
REQ-009 o_busy  output  1  high while a frame is in progress.
REQ-010 o_done_stb  output  1  one-cycle pulse when a frame completes.
REQ-011 o_sclk  output  1  serial clock to the display driver.
REQ-012 o_sdata  output  1  serial data, MSB first, valid while o_sclk rises.
REQ-013 o_latch  output  1  display-driver load pulse after the last bit.

Function
REQ-014 All outputs SHALL be registered; states SHALL be IDLE, CONVERT, SHIFT_LOW, SHIFT_HIGH, LATCH.
REQ-015 IDLE: on i_start_stb, the block SHALL capture i_hours/i_minutes/i_seconds, enter CONVERT, and raise o_busy on the next cycle; i_serial_stb SHALL be ignored in IDLE.
REQ-016 i_start_stb in any state other than IDLE SHALL be ignored; captured values SHALL be unaffected by later input changes.
REQ-017 CONVERT: every clock, each of the three remainders that is >=10 SHALL be reduced by 10 and its tens counter incremented, in parallel; i_serial_stb SHALL be ignored.
REQ-018 CONVERT SHALL exit on the first cycle in which all three remainders are <10, loading the 24-bit frame {hT,hU,mT,mU,sT,sU} (4 bits each) and entering SHIFT_LOW; worst case 23:59:59 takes 6 clocks in CONVERT.
REQ-019 Out-of-range inputs SHALL be converted arithmetically, without clamping (e.g. hours 31 -> 3,1; minutes 63 -> 6,3).
REQ-020 SHIFT_LOW: o_sclk=0 and o_sdata = current frame MSB; on i_serial_stb, go to SHIFT_HIGH with o_sclk=1.
REQ-021 SHIFT_HIGH: on i_serial_stb, set o_sclk=0 and shift the frame left by one; after the 24th bit go to LATCH, else to SHIFT_LOW.
REQ-022 Exactly 24 rising o_sclk edges SHALL occur per frame; o_sdata SHALL be stable for the full high phase of o_sclk.
REQ-023 LATCH: o_latch=1, o_sdata=0, o_sclk=0; on i_serial_stb, o_latch=0, o_done_stb=1 for one cycle, o_busy=0, return to IDLE.
REQ-024 A frame SHALL take 49 i_serial_stb pulses after CONVERT (48 bit half-periods plus 1 latch period).
REQ-025 i_start_stb coincident with the final LATCH i_serial_stb SHALL be ignored; a new start is accepted from the IDLE cycle onward.

Reset
REQ-026 Asserting i_reset_n low SHALL immediately force IDLE with o_busy=0, o_done_stb=0, o_sclk=0, o_sdata=0, o_latch=0, and clear the frame, counters and bit index, including mid-frame.
REQ-027 After reset release, no frame SHALL start without a new i_start_stb.

Verification
REQ-028 Capture 12:34:56, BLANK_LEADING_ZERO=0, i_serial_stb every 4 clocks -> bits sampled on o_sclk rise = 24'h123456, then one o_latch pulse, then o_done_stb.
REQ-029 Capture 23:59:59 -> CONVERT lasts 6 clocks, frame 24'h235959; capture 00:00:00 -> frame 24'h000000.
REQ-030 BLANK_LEADING_ZERO=1, capture 09:05:00 -> frame 24'hF90500; capture 10:00:00 -> 24'h100000.
REQ-031 Pulse i_start_stb with 01:02:03 mid-shift of a 12:34:56 frame -> the frame remains 24'h123456, and there is exactly one o_done_stb.
REQ-032 Assert i_reset_n after the 10th o_sclk edge -> all outputs 0 at once; after release, a 12:34:56 start yields a clean full 24'h123456 frame.
REQ-033 Count events per frame -> 24 o_sclk rises, 1 o_latch pulse, 1 o_done_stb, and o_busy high continuously from start+1 to done.
